seg_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the shared 7-seg decode path of the score display.

---
 rtl/seg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS BCD digits onto one shared 7-seg decode path. Each digit is preceded by a blanking gap.
// New scores are taken only at frame boundaries. Supports leading-zero suppression and a game-over flash.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int ON_CYCLES    = 20,
    parameter int BLANK_CYCLES = 2,
    parameter int FLASH_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic                    lz_suppress,
    input  logic                    flash_en,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    seg_en,
    output logic                    frame_start
);

    localparam int PMAX = ((ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES) - 1;
    localparam int PW   = (PMAX > 0) ? $clog2(PMAX + 1) : 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FR_LAST    = FW'(FLASH_FRAMES - 1);

    typedef enum logic {BLANK, ON} phase_t;

    phase_t                  phase;
    logic [IW-1:0]           idx;
    logic [PW-1:0]           pcnt;
    logic [FW-1:0]           fcnt;
    logic                    flash_phase;
    logic                    lz_q;
    logic                    frame_start_q;
    logic [4*NUM_DIGITS-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase         <= BLANK;
            idx           <= '0;
            pcnt          <= '0;
            fcnt          <= '0;
            flash_phase   <= 1'b0;
            lz_q          <= 1'b0;
            frame_start_q <= 1'b0;
            shadow        <= '0;
        end else begin
            // lz_suppress is registered so no input reaches an output combinationally
            lz_q          <= lz_suppress;
            frame_start_q <= 1'b0;
            if (upd_valid && upd_ready)
                shadow <= bcd_in;
            if (!flash_en) begin
                fcnt        <= '0;
                flash_phase <= 1'b0;
            end
            if (phase == BLANK) begin
                if (pcnt == BLANK_LAST) begin
                    pcnt  <= '0;
                    phase <= ON;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end else begin
                if (pcnt == ON_LAST) begin
                    pcnt  <= '0;
                    phase <= BLANK;
                    if (idx == IDX_LAST) begin
                        idx           <= '0;
                        frame_start_q <= 1'b1;
                        if (flash_en) begin
                            if (fcnt == FR_LAST) begin
                                fcnt        <= '0;
                                flash_phase <= ~flash_phase;
                            end else begin
                                fcnt <= fcnt + FW'(1);
                            end
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end

    logic       on_phase;
    logic [3:0] cur_code;
    logic       cur_supp;

    // A digit above position 0 is a leading zero when it and every digit above it are zero
    always_comb begin
        on_phase  = (phase == ON);
        cur_code  = 4'd0;
        cur_supp  = 1'b0;
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code     = shadow[4*i +: 4];
                cur_supp     = (i != 0) && ((shadow >> (4*i)) == '0);
                digit_sel[i] = on_phase;
            end
        end
    end

    assign upd_ready   = (phase == BLANK) && (idx == '0);
    assign frame_start = frame_start_q;
    assign seg_en      = on_phase && !(lz_q && cur_supp) && !flash_phase;
    assign digit_code  = (on_phase && !(lz_q && cur_supp)) ? cur_code : 4'd0;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a cycle-position reference model checked against the DUT every cycle.
// Directed scenarios are followed by a long randomized run.
module tb_seg_scan_ctrl;

    localparam int ND    = 2;
    localparam int ONC   = 20;
    localparam int BL    = 2;
    localparam int FF    = 2;
    localparam int SLOT  = BL + ONC;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*ND-1:0] bcd_in = '0;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic          lz_suppress = 1'b0;
    logic          flash_en = 1'b0;
    logic [3:0]    digit_code;
    logic [ND-1:0] digit_sel;
    logic          seg_en;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND), .ON_CYCLES(ONC), .BLANK_CYCLES(BL), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .lz_suppress(lz_suppress), .flash_en(flash_en), .digit_code(digit_code),
        .digit_sel(digit_sel), .seg_en(seg_en), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [8:0] dut_vec;
    assign dut_vec = {upd_ready, frame_start, seg_en, digit_sel, digit_code};
    localparam logic [8:0] RESET_VEC = 9'b1_0_0_00_0000;

    // Reference model: cycle number since reset, displayed value, wraps counted with flash on
    int        cyc = 0;
    logic [4*ND-1:0] shadow_m = '0;
    int        k = 0;
    logic      lz_prev = 1'b0;
    int        mt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; shadow_m = '0; k = 0; lz_prev = 1'b0;
        end else begin
            mt = cyc % FRAME;
            if (upd_valid && mt < BL) shadow_m = bcd_in;
            if (!flash_en) k = 0;
            else if (mt == FRAME - 1) k++;
            lz_prev = lz_suppress;
            cyc++;
        end
    end

    function automatic logic [8:0] model_out();
        int t, d, w;
        logic on, supp, foff, seg;
        logic [3:0] dig, code;
        logic [ND-1:0] sel;
        t    = cyc % FRAME;
        d    = t / SLOT;
        w    = t % SLOT;
        on   = (w >= BL);
        dig  = shadow_m[4*d +: 4];
        supp = lz_prev && (d > 0) && ((shadow_m >> (4*d)) == '0);
        foff = ((k / FF) % 2) == 1;
        sel  = on ? ND'(1 << d) : '0;
        code = (on && !supp) ? dig : 4'd0;
        seg  = on && !supp && !foff;
        return {t < BL, (t == 0) && (cyc > 0), seg, sel, code};
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        upd_valid = 1'b0; lz_suppress = 1'b0; flash_en = 1'b0; bcd_in = '0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec, RESET_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_frame();
        repeat (2 * FRAME + 2) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL idle cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            if (cyc == 2 || cyc == 44 || cyc == 30) begin
                checks++;
                if ((cyc == 2 && (digit_sel !== 2'b01 || seg_en !== 1'b1)) ||
                    (cyc == 30 && digit_sel !== 2'b10) ||
                    (cyc == 44 && frame_start !== 1'b1)) begin
                    errors++; $display("FAIL idle_fixed cyc=%0d: got %b", cyc, dut_vec);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_update();
        do_reset();
        repeat (3 * FRAME) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL update cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            if (cyc == 30 || cyc == 50 || cyc == 70) begin
                checks++;
                if ((cyc == 30 && digit_code !== 4'd0) || (cyc == 50 && digit_code !== 4'd7) ||
                    (cyc == 70 && digit_code !== 4'd3)) begin
                    errors++; $display("FAIL update_code cyc=%0d: got %0d", cyc, digit_code);
                end
            end
            if (cyc == 5) begin upd_valid = 1'b1; bcd_in = 8'h37; end
            if (cyc == 46) upd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_lz();
        do_reset();
        lz_suppress = 1'b1;
        repeat (6 * FRAME) begin
            if (cyc == 0)   begin upd_valid = 1'b1; bcd_in = 8'h05; end
            if (cyc == 88)  begin upd_valid = 1'b1; bcd_in = 8'h00; end
            if (cyc == 176) begin upd_valid = 1'b1; bcd_in = 8'h50; end
            if (cyc == 2 || cyc == 90 || cyc == 178) upd_valid = 1'b0;
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL lz cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            if (cyc == 70 || cyc == 50 || cyc == 134) begin
                checks++;
                if ((cyc == 70 && {digit_sel, seg_en} !== 3'b10_0) ||
                    (cyc == 50 && {digit_sel, seg_en, digit_code} !== 7'b01_1_0101) ||
                    (cyc == 134 && {digit_sel, seg_en, digit_code} !== 7'b01_1_0000)) begin
                    errors++; $display("FAIL lz_fixed cyc=%0d: got %b", cyc, dut_vec);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flash();
        do_reset();
        flash_en = 1'b1;
        repeat (5 * FRAME) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL flash cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            if (cyc == 60 || cyc == 95 || cyc == 102) begin
                checks++;
                if (seg_en !== (cyc != 95)) begin
                    errors++; $display("FAIL flash_fixed cyc=%0d: got %b", cyc, seg_en);
                end
            end
            if (cyc == 100) flash_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        upd_valid = 1'b1; bcd_in = 8'h37;
        while (cyc < 30) begin
            if (cyc == 2) upd_valid = 1'b0;
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL pre_reset cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++; $display("FAIL mid_reset: got %b want %b", dut_vec, RESET_VEC);
        end
        @(negedge clk); rst = 1'b0;
        repeat (FRAME + 10) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL post_reset cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [3:0] held [ND];
        logic       seen [ND];
        int         t;
        do_reset();
        repeat (1000 * FRAME) begin
            checks++;
            if (dut_vec !== model_out()) begin
                errors++; $display("FAIL random cyc=%0d: got %b want %b", cyc, dut_vec, model_out());
            end
            checks++;
            if (!$onehot0(digit_sel)) begin
                errors++; $display("FAIL onehot cyc=%0d: got %b", cyc, digit_sel);
            end
            t = cyc % FRAME;
            if (t == 0) for (int d = 0; d < ND; d++) seen[d] = 1'b0;
            for (int d = 0; d < ND; d++) begin
                if (digit_sel[d]) begin
                    if (seen[d]) begin
                        checks++;
                        if (digit_code !== held[d]) begin
                            errors++; $display("FAIL stable cyc=%0d: got %0d held %0d", cyc, digit_code, held[d]);
                        end
                    end
                    seen[d] = 1'b1; held[d] = digit_code;
                end
            end
            if (!upd_valid) bcd_in = ND*4'($urandom);
            upd_valid = $urandom_range(0, 1) == 1;
            if (t == FRAME - 5) begin
                lz_suppress = $urandom_range(0, 1) == 1;
                flash_en    = $urandom_range(0, 3) != 0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_update();
        test_lz();
        test_flash();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
